// File: rtl/general_reg_file_if.sv
// Register-file access bus: two combinational read ports and one clocked write port.
interface general_reg_file_if;
   logic [4:0]  RA;
   logic [4:0]  RB;
   logic [4:0]  RW;
   logic [31:0] busW;
   logic        RegWrite;
   logic [31:0] busA;
   logic [31:0] busB;

   modport master (
      output RA, RB, RW, busW, RegWrite,
      input  busA, busB
   );

   modport slave (
      input  RA, RB, RW, busW, RegWrite,
      output busA, busB
   );
endinterface

// File: rtl/general_reg_file.sv
// 32 x 32-bit register file, register 0 hardwired to zero, two async read ports.
module general_reg_file (
   input  logic                  clk,
   input  logic                  reset,
   general_reg_file_if.slave     bus
);

   logic [31:0] regs [32];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (bus.RegWrite && (bus.RW != 5'd0)) begin
         regs[bus.RW] <= bus.busW;
      end
   end

   // Reads come straight from storage: no bypass of the in-flight write data.
   assign bus.busA = (bus.RA == 5'd0) ? 32'h0 : regs[bus.RA];
   assign bus.busB = (bus.RB == 5'd0) ? 32'h0 : regs[bus.RB];

endmodule

// File: tb/tb_general_reg_file.sv
// Directed self-checking bench for general_reg_file.
module tb_general_reg_file;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   general_reg_file_if bus ();

   general_reg_file dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset        = 1'b0;
      bus.RegWrite = 1'b0;
      bus.RW       = 5'd0;
      bus.busW     = 32'h0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.RegWrite = 1'b0;
      tick();
      idle();
      for (int i = 0; i < 32; i++) begin
         bus.RA = 5'(i);
         bus.RB = 5'(31 - i);
         #1;
         checks++;
         if (bus.busA !== 32'h0 || bus.busB !== 32'h0) begin
            errors++;
            $display("FAIL reset_sweep RA=%0d RB=%0d: busA=%h busB=%h expected 0", i, 31 - i, bus.busA, bus.busB);
         end
      end
   endtask

   task automatic test_write_r0();
      bus.RW = 5'd0; bus.busW = 32'd1234; bus.RegWrite = 1'b1;
      tick();
      idle();
      bus.RA = 5'd0; bus.RB = 5'd0;
      #1;
      checks++;
      if (bus.busA !== 32'h0) begin
         errors++;
         $display("FAIL write_r0: busA=%h expected 00000000", bus.busA);
      end
   endtask

   task automatic test_basic();
      bus.RW = 5'd12; bus.busW = 32'hDEADBEEF; bus.RegWrite = 1'b1;
      tick();
      idle();
      bus.RB = 5'd12; bus.RA = 5'd13;
      #1;
      checks++;
      if (bus.busB !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL basic_busB: busB=%h expected deadbeef", bus.busB);
      end
      checks++;
      if (bus.busA !== 32'h0) begin
         errors++;
         $display("FAIL basic_busA: busA=%h expected 00000000", bus.busA);
      end
   endtask

   task automatic test_we_low();
      bus.RegWrite = 1'b0; bus.RW = 5'd12; bus.busW = 32'd5;
      tick();
      bus.RB = 5'd12;
      #1;
      checks++;
      if (bus.busB !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL we_low: busB=%h expected deadbeef", bus.busB);
      end
      // Undefined write address/data with the enable low must leave storage alone.
      bus.RW = 5'bx; bus.busW = 32'bx;
      tick();
      idle();
      bus.RA = 5'd12;
      #1;
      checks++;
      if (bus.busA !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL xz_no_corrupt: busA=%h expected deadbeef", bus.busA);
      end
   endtask

   task automatic test_no_bypass();
      @(negedge clk);
      bus.RA = 5'd7; bus.RW = 5'd7; bus.busW = 32'h55; bus.RegWrite = 1'b1;
      #1;
      checks++;
      if (bus.busA !== 32'h0) begin
         errors++;
         $display("FAIL no_bypass_before: busA=%h expected 00000000", bus.busA);
      end
      tick();
      idle();
      checks++;
      if (bus.busA !== 32'h55) begin
         errors++;
         $display("FAIL no_bypass_after: busA=%h expected 00000055", bus.busA);
      end
   endtask

   task automatic test_same_addr();
      bus.RA = 5'd9; bus.RB = 5'd9; bus.RW = 5'd9; bus.busW = 32'hA5A5_0F0F; bus.RegWrite = 1'b1;
      tick();
      idle();
      checks++;
      if (bus.busA !== 32'hA5A5_0F0F || bus.busB !== 32'hA5A5_0F0F) begin
         errors++;
         $display("FAIL same_addr: busA=%h busB=%h expected a5a50f0f", bus.busA, bus.busB);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [4];
      vals[0] = 32'h1111_1111; vals[1] = 32'h8000_0001;
      vals[2] = 32'hFFFF_FFFF; vals[3] = 32'h0123_4567;
      for (int i = 0; i < 4; i++) begin
         bus.RW = 5'(20 + i); bus.busW = vals[i]; bus.RegWrite = 1'b1;
         tick();
      end
      bus.RW = 5'd31; bus.busW = 32'hCAFE_F00D;
      tick();
      bus.RW = 5'd31; bus.busW = 32'hBEEF_0001;
      tick();
      idle();
      for (int i = 0; i < 4; i++) begin
         bus.RA = 5'(20 + i); bus.RB = 5'(23 - i);
         #1;
         checks++;
         if (bus.busA !== vals[i] || bus.busB !== vals[3 - i]) begin
            errors++;
            $display("FAIL back_to_back idx=%0d: busA=%h busB=%h expected %h %h", i, bus.busA, bus.busB, vals[i], vals[3 - i]);
         end
      end
      bus.RA = 5'd31;
      #1;
      checks++;
      if (bus.busA !== 32'hBEEF_0001) begin
         errors++;
         $display("FAIL overwrite_r31: busA=%h expected beef0001", bus.busA);
      end
   endtask

   task automatic test_reset_priority();
      reset = 1'b1; bus.RegWrite = 1'b1; bus.RW = 5'd3; bus.busW = 32'hFFFF_FFFF;
      tick();
      idle();
      for (int i = 0; i < 32; i++) begin
         bus.RA = 5'(i); bus.RB = 5'(i);
         #1;
         checks++;
         if (bus.busA !== 32'h0 || bus.busB !== 32'h0) begin
            errors++;
            $display("FAIL reset_priority reg=%0d: busA=%h busB=%h expected 0", i, bus.busA, bus.busB);
         end
      end
   endtask

   task automatic test_reset_release();
      reset = 1'b1;
      tick();
      reset = 1'b0; bus.RegWrite = 1'b1; bus.RW = 5'd5; bus.busW = 32'h0BAD_CAFE;
      tick();
      idle();
      bus.RA = 5'd5;
      #1;
      checks++;
      if (bus.busA !== 32'h0BAD_CAFE) begin
         errors++;
         $display("FAIL reset_release: busA=%h expected 0badcafe", bus.busA);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      idle();
      bus.RA = 5'd0;
      bus.RB = 5'd0;
      @(negedge clk);
      test_reset();
      test_write_r0();
      test_basic();
      test_we_low();
      test_no_bypass();
      test_same_addr();
      test_back_to_back();
      test_reset_priority();
      test_reset_release();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
